// File: rtl/issue_scheduler_if.sv
// Decode, credit and writeback bundle between the issue scheduler and its neighbours.
// Perf counter signals are present only when ISSUE_PERF_COUNTERS_EN is defined.
interface issue_scheduler_if #(
    parameter int ROB_DEPTH = 32
);
    localparam int ROB_W = $clog2(ROB_DEPTH + 1);

    logic             redirect;
    logic             instructionsValid;
    logic             badData;
    logic             isMem0;
    logic             isMem1;
    logic             isLoad0;
    logic             isBranch0;
    logic             isBranch1;
    logic             writesRd0;
    logic             writesRd1;
    logic [4:0]       rd0;
    logic [4:0]       rd1;
    logic [4:0]       rs1_0;
    logic [4:0]       rs2_0;
    logic [4:0]       rs1_1;
    logic [4:0]       rs2_1;
    logic [1:0]       robRetire;
    logic             memqDequeue;
    logic             loadDoneValid;
    logic [4:0]       loadDoneRd;
    logic             instructionConsumed1;
    logic             instructionConsumed2;
    logic [1:0]       robAlloc;
    logic             memqAlloc;
    logic [ROB_W-1:0] robFree;
`ifdef ISSUE_PERF_COUNTERS_EN
    logic [31:0]      perfDual;
    logic [31:0]      perfSingle;
    logic [31:0]      perfStall;
`endif

    modport master (
        output redirect, instructionsValid, badData, isMem0, isMem1, isLoad0,
               isBranch0, isBranch1, writesRd0, writesRd1, rd0, rd1,
               rs1_0, rs2_0, rs1_1, rs2_1, robRetire, memqDequeue,
               loadDoneValid, loadDoneRd,
        input  instructionConsumed1, instructionConsumed2, robAlloc, memqAlloc, robFree
`ifdef ISSUE_PERF_COUNTERS_EN
        , input perfDual, perfSingle, perfStall
`endif
    );

    modport slave (
        input  redirect, instructionsValid, badData, isMem0, isMem1, isLoad0,
               isBranch0, isBranch1, writesRd0, writesRd1, rd0, rd1,
               rs1_0, rs2_0, rs1_1, rs2_1, robRetire, memqDequeue,
               loadDoneValid, loadDoneRd,
        output instructionConsumed1, instructionConsumed2, robAlloc, memqAlloc, robFree
`ifdef ISSUE_PERF_COUNTERS_EN
        , output perfDual, perfSingle, perfStall
`endif
    );
endinterface

// File: rtl/issue_scheduler.sv
// Dual-slot issue controller: ROB/memory-queue credits, pending-load scoreboard, redirect flush.
// Optional perf counters (perfDual/perfSingle/perfStall) when ISSUE_PERF_COUNTERS_EN is defined.
module issue_scheduler #(
    parameter int ROB_DEPTH    = 32,
    parameter int MEMQ_DEPTH   = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input logic              clock,
    input logic              reset,
    issue_scheduler_if.slave bus
);
    localparam int ROB_W   = $clog2(ROB_DEPTH + 1);
    localparam int MEMQ_W  = $clog2(MEMQ_DEPTH + 1);
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [ROB_W-1:0]   ROB_FULL     = ROB_W'(ROB_DEPTH);
    localparam logic [MEMQ_W-1:0]  MEMQ_FULL    = MEMQ_W'(MEMQ_DEPTH);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t              state, stateNext;
    logic [FLUSH_W-1:0]  flushCount, flushCountNext;
    logic [ROB_W-1:0]    robFree, robFreeNext;
    logic [MEMQ_W-1:0]   memqFree, memqFreeNext;
    logic [31:0]         scoreboard, scoreboardNext;
    logic [ROB_W:0]      robSum;
    logic [MEMQ_W:0]     memqSum;
    logic [4:0]          rd0Eff, rd1Eff;
    logic                slot0Ok, slot1Ok, loadIssue;

    always_comb begin
        stateNext      = state;
        flushCountNext = flushCount;
        if (bus.redirect) begin
            stateNext      = FLUSH;
            flushCountNext = FLUSH_RELOAD;
        end else begin
            case (state)
                FILL, FLUSH: begin
                    if (flushCount == '0) stateNext = RUN;
                    else                  flushCountNext = flushCount - 1'b1;
                end
                RUN:     stateNext = RUN;
                default: stateNext = FILL;
            endcase
        end
    end

    // Hazard checks read the registered scoreboard only, so a load finishing this cycle still blocks.
    always_comb begin
        rd0Eff  = bus.writesRd0 ? bus.rd0 : 5'd0;
        rd1Eff  = bus.writesRd1 ? bus.rd1 : 5'd0;
        slot0Ok = (state == RUN) && !bus.redirect && bus.instructionsValid
                  && (robFree >= ROB_W'(1))
                  && (!bus.isMem0 || (memqFree >= MEMQ_W'(2)))
                  && !scoreboard[bus.rs1_0] && !scoreboard[bus.rs2_0] && !scoreboard[rd0Eff];
        slot1Ok = slot0Ok && !bus.badData && !bus.isMem1
                  && (robFree >= ROB_W'(2))
                  && !(bus.isBranch0 && bus.isBranch1)
                  && ((rd0Eff == 5'd0)
                      || ((rd0Eff != bus.rs1_1) && (rd0Eff != bus.rs2_1) && (rd0Eff != rd1Eff)))
                  && !scoreboard[bus.rs1_1] && !scoreboard[bus.rs2_1] && !scoreboard[rd1Eff];
        loadIssue = slot0Ok && bus.isMem0 && bus.isLoad0 && (rd0Eff != 5'd0);
    end

    assign bus.instructionConsumed1 = slot0Ok;
    assign bus.instructionConsumed2 = slot1Ok;
    assign bus.robAlloc             = {1'b0, slot0Ok} + {1'b0, slot1Ok};
    assign bus.memqAlloc            = slot0Ok && bus.isMem0;
    assign bus.robFree              = robFree;

    always_comb begin
        robSum         = {1'b0, robFree} - (ROB_W + 1)'(bus.robAlloc) + (ROB_W + 1)'(bus.robRetire);
        robFreeNext    = (robSum > {1'b0, ROB_FULL}) ? ROB_FULL : robSum[ROB_W-1:0];
        memqSum        = {1'b0, memqFree} - (MEMQ_W + 1)'(bus.memqAlloc)
                         + (MEMQ_W + 1)'(bus.memqDequeue);
        memqFreeNext   = (memqSum > {1'b0, MEMQ_FULL}) ? MEMQ_FULL : memqSum[MEMQ_W-1:0];
        scoreboardNext = scoreboard;
        if (bus.loadDoneValid) scoreboardNext[bus.loadDoneRd] = 1'b0;
        if (loadIssue)         scoreboardNext[rd0Eff]         = 1'b1;
        scoreboardNext[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            flushCount <= FLUSH_RELOAD;
            robFree    <= ROB_FULL;
            memqFree   <= MEMQ_FULL;
            scoreboard <= '0;
        end else begin
            state      <= stateNext;
            flushCount <= flushCountNext;
            if (bus.redirect) begin
                robFree    <= ROB_FULL;
                memqFree   <= MEMQ_FULL;
                scoreboard <= '0;
            end else begin
                robFree    <= robFreeNext;
                memqFree   <= memqFreeNext;
                scoreboard <= scoreboardNext;
            end
        end
    end

`ifdef ISSUE_PERF_COUNTERS_EN
    logic [31:0] perfDualReg, perfSingleReg, perfStallReg;

    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perfDualReg   <= '0;
            perfSingleReg <= '0;
            perfStallReg  <= '0;
        end else begin
            if (slot0Ok && slot1Ok)  perfDualReg   <= perfDualReg + 32'd1;
            if (slot0Ok && !slot1Ok) perfSingleReg <= perfSingleReg + 32'd1;
            if ((state == RUN) && bus.instructionsValid && !slot0Ok)
                perfStallReg <= perfStallReg + 32'd1;
        end
    end

    assign bus.perfDual   = perfDualReg;
    assign bus.perfSingle = perfSingleReg;
    assign bus.perfStall  = perfStallReg;
`endif
endmodule
